spi_master_param: RTL and testbench

//  Parametrised SPI master: NBITS-wide words, variable packet size, NCS chip selects, programmable sclk divider.

---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_master_param_ctrl.sv | 105 ++++++++++
 rtl/spi_master_param.sv | 153 +++++++++++++++
 tb/tb_spi_master_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types for the parametrised SPI master.
// Controller states, mode bit positions and a state helper.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    LEAD     = 3'd2,
    TRAIL    = 3'd3,
    CS_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  // True while the selected peripheral's chip select is driven low
  function automatic logic cs_active(state_t s);
    return (s == CS_SETUP) || (s == LEAD) ||
           (s == TRAIL) || (s == CS_HOLD);
  endfunction

endpackage

// File: rtl/spi_master_param_ctrl.sv
// Transfer sequencer: FSM, half-period counter, bit counter.
// Emits load/sample/shift strobes that act on the next clk edge.
module spi_master_param_ctrl
  import spi_master_pkg::*;
#(
  parameter int PSW   = 6,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             cpha_i,
  input  logic             send_rdy_i,
  input  logic [PSW-1:0]   ps_i,
  input  logic [DIV_W-1:0] div_i,
  output state_t           state_o,
  output logic             load_o,
  output logic             sample_o,
  output logic             shift_o
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PSW-1:0]     bit_q, bit_d;
  logic               tick;
  logic               last;
  logic               ent_lead;
  logic               ent_trail;

  assign tick = (cnt_q == div_i);
  assign last = (bit_q == ps_i - 1'b1);

  // Next-state, half-period and bit-count logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    ent_lead  = 1'b0;
    ent_trail = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      CS_SETUP: begin
        if (tick) begin
          state_d  = LEAD;
          ent_lead = 1'b1;
        end
      end
      LEAD: begin
        if (tick) begin
          state_d   = TRAIL;
          ent_trail = 1'b1;
        end
      end
      TRAIL: begin
        if (tick) begin
          if (last) begin
            state_d = CS_HOLD;
          end else begin
            state_d  = LEAD;
            ent_lead = 1'b1;
            bit_d    = bit_q + 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (tick) state_d = DONE;
      end
      DONE: begin
        if (send_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cs_active(state_q)) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // CPHA=1 skips the shift on the first leading edge, since the
  // first bit is already on mosi from CS_SETUP.
  assign state_o  = state_q;
  assign load_o   = start_i && (state_q == IDLE);
  assign sample_o = cpha_i ? ent_trail : ent_lead;
  assign shift_o  = cpha_i ? (ent_lead && state_q == TRAIL)
                           : ent_trail;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: config regs, shift regs, cs decode.
// Optional SPI_MASTER_MODE_EN adds a runtime {CPOL,CPHA} mode port.
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter  int NBITS = 32,
  parameter  int NCS   = 4,
  parameter  int DIV_W = 8,
  localparam int PSW   = $clog2(NBITS) + 1,
  localparam int AW    = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [NBITS-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [NBITS-1:0] send_msg,
  input  logic             packet_size_val,
  output logic             packet_size_rdy,
  input  logic [PSW-1:0]   packet_size_msg,
  input  logic             cs_addr_val,
  output logic             cs_addr_rdy,
  input  logic [AW-1:0]    cs_addr_msg,
  input  logic             freq_val,
  output logic             freq_rdy,
  input  logic [DIV_W-1:0] freq_msg,
`ifdef SPI_MASTER_MODE_EN
  input  logic             mode_val,
  output logic             mode_rdy,
  input  logic [1:0]       mode_msg,
`endif
  output logic [NCS-1:0]   cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  state_t           state;
  logic             cfg_rdy;
  logic             recv_fire;
  logic             load;
  logic             sample;
  logic             shift;
  logic [PSW-1:0]   ps_q;
  logic [AW-1:0]    addr_q;
  logic [DIV_W-1:0] freq_q;
  logic [PSW-1:0]   ps_raw;
  logic [PSW-1:0]   ps_cur;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [1:0]       mode;

  assign cfg_rdy         = (state == IDLE) && !reset;
  assign recv_rdy        = cfg_rdy;
  assign packet_size_rdy = cfg_rdy;
  assign cs_addr_rdy     = cfg_rdy;
  assign freq_rdy        = cfg_rdy;
  assign recv_fire       = recv_val && cfg_rdy;

  // A size written alongside the word applies to that word
  assign ps_raw = (packet_size_val && cfg_rdy) ? packet_size_msg
                                               : ps_q;
  assign ps_cur = (ps_raw == '0 || ps_raw > PSW'(NBITS))
                ? PSW'(NBITS) : ps_raw;

  // Configuration registers, writable only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q   <= PSW'(NBITS);
      addr_q <= '0;
      freq_q <= '0;
    end else begin
      if (packet_size_val && cfg_rdy) ps_q   <= packet_size_msg;
      if (cs_addr_val && cfg_rdy)     addr_q <= cs_addr_msg;
      if (freq_val && cfg_rdy)        freq_q <= freq_msg;
    end
  end

`ifdef SPI_MASTER_MODE_EN
  logic [1:0] mode_q;

  assign mode_rdy = cfg_rdy;
  assign mode     = mode_q;

  // Mode register, writable only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 2'b00;
    end else if (mode_val && cfg_rdy) begin
      mode_q <= mode_msg;
    end
  end
`else
  assign mode = 2'b00;
`endif

  spi_master_param_ctrl #(
    .PSW   (PSW),
    .DIV_W (DIV_W)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start_i    (recv_fire),
    .cpha_i     (mode[MODE_CPHA]),
    .send_rdy_i (send_rdy),
    .ps_i       (ps_cur),
    .div_i      (freq_q),
    .state_o    (state),
    .load_o     (load),
    .sample_o   (sample),
    .shift_o    (shift)
  );

  // Shift registers: tx left-justified on load, rx fills from LSB
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load) begin
      tx_d = recv_msg << (PSW'(NBITS) - ps_cur);
      rx_d = '0;
    end else begin
      if (shift)  tx_d = {tx_q[NBITS-2:0], 1'b0};
      if (sample) rx_d = {rx_q[NBITS-2:0], miso};
    end
  end

  // Shift register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  // Active-low chip select; out-of-range index selects nothing
  always_comb begin
    cs = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cs_active(state) && int'(addr_q) == i) cs[i] = 1'b0;
    end
  end

  assign sclk     = mode[MODE_CPOL] ^ (state == LEAD);
  assign mosi     = tx_q[NBITS-1];
  assign send_val = (state == DONE);
  assign send_msg = rx_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param with mosi looped to miso.
// Mode test runs only when SPI_MASTER_MODE_EN is defined.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [31:0] recv_msg = '0;
  logic        send_val;
  logic        send_rdy = 1'b0;
  logic [31:0] send_msg;
  logic        packet_size_val = 1'b0;
  logic        packet_size_rdy;
  logic [5:0]  packet_size_msg = '0;
  logic        cs_addr_val = 1'b0;
  logic        cs_addr_rdy;
  logic [1:0]  cs_addr_msg = '0;
  logic        freq_val = 1'b0;
  logic        freq_rdy;
  logic [7:0]  freq_msg = '0;
  logic        mode_val = 1'b0;
  logic        mode_rdy;
  logic [1:0]  mode_msg = '0;
  logic [3:0]  cs;
  logic        sclk;
  logic        mosi;
  logic        miso;

  assign miso = mosi;

  always #5 clk = ~clk;

  spi_master_param #(
    .NBITS (32),
    .NCS   (4),
    .DIV_W (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .recv_val        (recv_val),
    .recv_rdy        (recv_rdy),
    .recv_msg        (recv_msg),
    .send_val        (send_val),
    .send_rdy        (send_rdy),
    .send_msg        (send_msg),
    .packet_size_val (packet_size_val),
    .packet_size_rdy (packet_size_rdy),
    .packet_size_msg (packet_size_msg),
    .cs_addr_val     (cs_addr_val),
    .cs_addr_rdy     (cs_addr_rdy),
    .cs_addr_msg     (cs_addr_msg),
    .freq_val        (freq_val),
    .freq_rdy        (freq_rdy),
    .freq_msg        (freq_msg),
`ifdef SPI_MASTER_MODE_EN
    .mode_val        (mode_val),
    .mode_rdy        (mode_rdy),
    .mode_msg        (mode_msg),
`endif
    .cs              (cs),
    .sclk            (sclk),
    .mosi            (mosi),
    .miso            (miso)
  );

`ifndef SPI_MASTER_MODE_EN
  assign mode_rdy = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          pulses;
  int          r1;
  int          f1;
  int          r2;
  logic [3:0]  csd;
  logic [31:0] rxd;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] d, input logic [5:0] ps,
                       input logic [7:0] dv, input logic [1:0] ad);
    @(negedge clk);
    recv_val        = 1'b1;
    recv_msg        = d;
    packet_size_val = 1'b1;
    packet_size_msg = ps;
    freq_val        = 1'b1;
    freq_msg        = dv;
    cs_addr_val     = 1'b1;
    cs_addr_msg     = ad;
    @(posedge clk);
    #1;
    recv_val        = 1'b0;
    packet_size_val = 1'b0;
    freq_val        = 1'b0;
    cs_addr_val     = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] d, input logic [5:0] ps,
                      input logic [7:0] dv, input logic [1:0] ad,
                      input int stall, input logic [31:0] exp);
    logic prev;
    start(d, ps, dv, ad);
    csd    = cs;
    prev   = sclk;
    lat    = 0;
    pulses = 0;
    r1     = -1;
    f1     = -1;
    r2     = -1;
    while (!send_val && lat < 4000) begin
      @(posedge clk);
      #1;
      lat++;
      if (sclk && !prev) begin
        pulses++;
        if (r1 < 0) r1 = lat;
        else if (r2 < 0) r2 = lat;
      end
      if (!sclk && prev && f1 < 0) f1 = lat;
      prev = sclk;
    end
    rxd = send_msg;
    for (int i = 0; i < stall; i++) begin
      recv_val = 1'b1;
      recv_msg = ~d;
      @(posedge clk);
      #1;
      chk("stall_val", send_val, 1);
      chk("stall_msg", send_msg, exp);
      chk("stall_rdy", recv_rdy, 0);
      chk("stall_cs", cs, 4'hF);
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    send_rdy = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_sval", send_val, 0);
    chk("rst_smsg", send_msg, 0);
    chk("rst_rrdy", recv_rdy, 0);
    chk("rst_psrdy", packet_size_rdy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rrdy", recv_rdy, 1);
    chk("idle_frdy", freq_rdy, 1);

    xfer(32'h0000_00A5, 6'd8, 8'd0, 2'd0, 0, 32'hA5);
    chk("t1_lat", lat, 18);
    chk("t1_pulses", pulses, 8);
    chk("t1_msg", rxd, 32'h0000_00A5);
    chk("t1_cs", csd, 4'b1110);
    chk("t1_cs_after", cs, 4'hF);
    chk("t1_rdy_after", recv_rdy, 1);

    xfer(32'hDEAD_BEEF, 6'd0, 8'd0, 2'd0, 0, 32'hDEADBEEF);
    chk("ps0_lat", lat, 66);
    chk("ps0_pulses", pulses, 32);
    chk("ps0_msg", rxd, 32'hDEAD_BEEF);

    xfer(32'hDEAD_BEEF, 6'd40, 8'd0, 2'd0, 0, 32'hDEADBEEF);
    chk("ps40_lat", lat, 66);
    chk("ps40_pulses", pulses, 32);
    chk("ps40_msg", rxd, 32'hDEAD_BEEF);

    xfer(32'h0000_00F9, 6'd4, 8'd3, 2'd2, 0, 32'h9);
    chk("div_lat", lat, 40);
    chk("div_r1", r1, 4);
    chk("div_high", f1 - r1, 4);
    chk("div_period", r2 - r1, 8);
    chk("div_pulses", pulses, 4);
    chk("div_cs", csd, 4'b1011);
    chk("div_msg", rxd, 32'h9);

    xfer(32'h0000_0006, 6'd4, 8'd3, 2'd2, 10, 32'h6);
    chk("stall_first", rxd, 32'h6);
    chk("stall_idle", recv_rdy, 1);
    chk("stall_sval", send_val, 0);

    start(32'h0000_BEEF, 6'd16, 8'd0, 2'd1);
    lat = 0;
    while (lat < 11) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mid_sclk", sclk, 1);
    chk("mid_cs", cs, 4'b1101);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_cs", cs, 4'hF);
    chk("abort_sclk", sclk, 0);
    chk("abort_sval", send_val, 0);
    chk("abort_mosi", mosi, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    xfer(32'h0000_003C, 6'd8, 8'd0, 2'd0, 0, 32'h3C);
    chk("post_lat", lat, 18);
    chk("post_msg", rxd, 32'h3C);
    chk("post_cs", csd, 4'b1110);

`ifdef SPI_MASTER_MODE_EN
    @(negedge clk);
    mode_val = 1'b1;
    mode_msg = 2'b11;
    @(posedge clk);
    #1;
    mode_val = 1'b0;
    chk("m3_idle_sclk", sclk, 1);
    xfer(32'h0000_005A, 6'd8, 8'd0, 2'd0, 0, 32'h5A);
    chk("m3_lat", lat, 18);
    chk("m3_msg", rxd, 32'h5A);
    chk("m3_pulses", pulses, 8);
    chk("m3_end_sclk", sclk, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
